// File: rtl/mem_bus_bridge_if.sv
// Data-bus handshake bundle between the load/store bridge and memory.
// The bridge drives requests; the memory side returns ack and read data.
interface mem_bus_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_wstrb,
        output bus_err,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_wstrb,
        input  bus_err,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// Memory-stage load/store sequencer onto a req/ack bus (IDLE -> BUSY -> DONE).
// Optional LSU_TIMEOUT_EN adds a BUSY watchdog with a sticky bus_err flag.
module mem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_readM,
    input  logic              mem_writeM,
    input  logic              store_typeM,
    input  logic [31:0]       addrM,
    input  logic [31:0]       wdataM,
    output logic [31:0]       read_dataM,
    output logic              stall_mem,
    mem_bus_bridge_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_bus_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        access;
    logic        timeout;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Fires on the TIMEOUT_CYCLES-th BUSY cycle that still has no ack.
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign bus.bus_err = err_q;
`else
    assign timeout = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    assign access    = mem_readM | mem_writeM;
    assign stall_mem = access & (state_q != DONE);

    assign read_dataM    = rdata_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wstrb = wstrb_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_writeM;
                    addr_d  = {addrM[31:2], 2'b00};
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (!mem_writeM) begin
                        wstrb_d = 4'b0000;
                        wdata_d = '0;
                    end else if (store_typeM) begin
                        wstrb_d = 4'b0001 << addrM[1:0];
                        wdata_d = {4{wdataM[7:0]}};
                    end else begin
                        wstrb_d = 4'b1111;
                        wdata_d = wdataM;
                    end
                end
            end
            BUSY: begin
                // Ack wins over a watchdog expiry in the same cycle.
                if (bus.bus_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = bus.bus_rdata;
                end else if (timeout) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = ERR_DATA;
`ifdef LSU_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end else begin
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: directed cases plus randomized
// accesses against a transaction-level reference model.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_readM, mem_writeM, store_typeM;
    logic [31:0] addrM, wdataM;
    logic [31:0] read_dataM;
    logic        stall_mem;

    mem_bus_bridge_if bus ();

    mem_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_readM  (mem_readM),
        .mem_writeM (mem_writeM),
        .store_typeM(store_typeM),
        .addrM      (addrM),
        .wdataM     (wdataM),
        .read_dataM (read_dataM),
        .stall_mem  (stall_mem),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // model state: last completed load value
    logic [31:0] exp_rd;

    // observations of the most recent access
    int          ob_stalls;
    bit          ob_done, ob_stable, ob_req_drop;
    logic [31:0] ob_addr, ob_wdata;
    logic [3:0]  ob_wstrb;
    logic        ob_we;

    // Drives one access starting at a negedge in IDLE; memory acks on the
    // nbusy-th cycle bus_req is seen high (nbusy=0: never acks).
    task automatic run_access(input bit rd, input bit wr, input bit st,
                              input logic [31:0] a, input logic [31:0] d,
                              input int nbusy, input logic [31:0] rdata);
        int busy;
        bit first;
        mem_readM = rd; mem_writeM = wr; store_typeM = st;
        addrM = a; wdataM = d;
        ob_stalls = 0; ob_done = 0; ob_stable = 1;
        busy = 0; first = 1;
        #1;
        for (int c = 0; c < 200; c++) begin
            if (!stall_mem) begin
                ob_done = 1;
                break;
            end
            ob_stalls++;
            if (bus.bus_req) begin
                busy++;
                if (first) begin
                    ob_addr = bus.bus_addr; ob_we = bus.bus_we;
                    ob_wdata = bus.bus_wdata; ob_wstrb = bus.bus_wstrb;
                    first = 0;
                end else if ({ob_addr, ob_we, ob_wdata, ob_wstrb} !==
                             {bus.bus_addr, bus.bus_we, bus.bus_wdata,
                              bus.bus_wstrb}) begin
                    ob_stable = 0;
                end
                if (busy == nbusy) begin
                    bus.bus_ack = 1'b1;
                    bus.bus_rdata = rdata;
                end
            end
            @(negedge clk);
            bus.bus_ack = 1'b0;
            bus.bus_rdata = $urandom;
        end
        ob_req_drop = !bus.bus_req;
        mem_readM = 0; mem_writeM = 0;
        addrM = $urandom; wdataM = $urandom;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({read_dataM, stall_mem, bus.bus_req, bus.bus_we} !== 35'd0)
            $display("FAIL reset_ctl got rd=%h st=%b req=%b we=%b want 0",
                     read_dataM, stall_mem, bus.bus_req, bus.bus_we);
        else n_pass++;
        n_chk++;
        if ({bus.bus_addr, bus.bus_wdata, bus.bus_wstrb, bus.bus_err} !== 69'd0)
            $display("FAIL reset_bus got a=%h d=%h s=%b e=%b want 0",
                     bus.bus_addr, bus.bus_wdata, bus.bus_wstrb, bus.bus_err);
        else n_pass++;
        reset = 0;
        exp_rd = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_word_load();
        run_access(1, 0, 0, 32'h104, 32'h0, 2, 32'h12345678);
        exp_rd = 32'h12345678;
        n_chk++;
        if (!ob_done || ob_stalls != 3)
            $display("FAIL wl_stall got %0d done=%0b want 3", ob_stalls, ob_done);
        else n_pass++;
        n_chk++;
        if ({ob_addr, ob_we, ob_wstrb} !== {32'h104, 1'b0, 4'b0000})
            $display("FAIL wl_bus got a=%h we=%b s=%b want 104/0/0000",
                     ob_addr, ob_we, ob_wstrb);
        else n_pass++;
        n_chk++;
        if (read_dataM !== exp_rd || !ob_stable || !ob_req_drop)
            $display("FAIL wl_data got %h stable=%0b drop=%0b want %h",
                     read_dataM, ob_stable, ob_req_drop, exp_rd);
        else n_pass++;
    endtask

    task automatic test_byte_store();
        run_access(0, 1, 1, 32'h203, 32'hAABBCCDD, 1, 32'h99999999);
        n_chk++;
        if ({ob_addr, ob_we, ob_wstrb, ob_wdata} !==
            {32'h200, 1'b1, 4'b1000, 32'hDDDDDDDD})
            $display("FAIL bs_bus got a=%h we=%b s=%b d=%h want 200/1/1000/DDDDDDDD",
                     ob_addr, ob_we, ob_wstrb, ob_wdata);
        else n_pass++;
        n_chk++;
        if (read_dataM !== exp_rd || ob_stalls != 2)
            $display("FAIL bs_keep got rd=%h stalls=%0d want %h/2",
                     read_dataM, ob_stalls, exp_rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_access(1, 0, 0, 32'h40, 32'h0, 1, 32'h0BADF00D);
        exp_rd = 32'h0BADF00D;
        n_chk++;
        if (ob_stalls != 2 || !ob_req_drop || read_dataM !== exp_rd)
            $display("FAIL b2b_load got stalls=%0d drop=%0b rd=%h want 2/1/%h",
                     ob_stalls, ob_req_drop, read_dataM, exp_rd);
        else n_pass++;
        run_access(0, 1, 0, 32'h47, 32'h13572468, 1, 32'h0);
        n_chk++;
        if (ob_stalls != 2 || !ob_req_drop ||
            {ob_addr, ob_wstrb, ob_wdata} !== {32'h44, 4'hF, 32'h13572468})
            $display("FAIL b2b_store got stalls=%0d a=%h s=%b d=%h want 2/44/1111/13572468",
                     ob_stalls, ob_addr, ob_wstrb, ob_wdata);
        else n_pass++;
    endtask

    task automatic test_both_high();
        run_access(1, 1, 0, 32'h30, 32'h55AA00FF, 1, 32'h77777777);
        n_chk++;
        if (ob_we !== 1'b1 || ob_wstrb !== 4'hF || read_dataM !== exp_rd)
            $display("FAIL both_hi got we=%b s=%b rd=%h want 1/1111/%h",
                     ob_we, ob_wstrb, read_dataM, exp_rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        mem_readM = 1; mem_writeM = 0; addrM = 32'h80;
        @(negedge clk);
        n_chk++;
        if (bus.bus_req !== 1'b1)
            $display("FAIL rm_busy got req=%b want 1", bus.bus_req);
        else n_pass++;
        #2 reset = 1; mem_readM = 0;
        #1;
        n_chk++;
        if ({bus.bus_req, stall_mem, read_dataM} !== 34'd0)
            $display("FAIL rm_async got req=%b st=%b rd=%h want 0/0/0",
                     bus.bus_req, stall_mem, read_dataM);
        else n_pass++;
        exp_rd = 32'h0;
        @(negedge clk);
        reset = 0;
        bus.bus_ack = 1; bus.bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.bus_ack = 0;
        @(negedge clk);
        n_chk++;
        if ({bus.bus_req, stall_mem} !== 2'b00 || read_dataM !== exp_rd)
            $display("FAIL rm_late_ack got req=%b st=%b rd=%h want 0/0/%h",
                     bus.bus_req, stall_mem, read_dataM, exp_rd);
        else n_pass++;
        run_access(1, 0, 0, 32'h84, 32'h0, 1, 32'h2468ACE0);
        exp_rd = 32'h2468ACE0;
        n_chk++;
        if (read_dataM !== exp_rd || ob_stalls != 2)
            $display("FAIL rm_recover got rd=%h stalls=%0d want %h/2",
                     read_dataM, ob_stalls, exp_rd);
        else n_pass++;
    endtask

    task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
        run_access(1, 0, 0, 32'h500, 32'h0, 0, 32'h0);
        exp_rd = 32'hDEADBEEF;
        n_chk++;
        if (!ob_done || ob_stalls != 5 || read_dataM !== exp_rd)
            $display("FAIL to_abort got stalls=%0d rd=%h want 5/%h",
                     ob_stalls, read_dataM, exp_rd);
        else n_pass++;
        run_access(1, 0, 0, 32'h504, 32'h0, 2, 32'h11223344);
        exp_rd = 32'h11223344;
        n_chk++;
        if (bus.bus_err !== 1'b1 || read_dataM !== exp_rd)
            $display("FAIL to_sticky got err=%b rd=%h want 1/%h",
                     bus.bus_err, read_dataM, exp_rd);
        else n_pass++;
        reset = 1;
        @(negedge clk);
        reset = 0;
        exp_rd = 32'h0;
        n_chk++;
        if (bus.bus_err !== 1'b0)
            $display("FAIL to_clear got err=%b want 0", bus.bus_err);
        else n_pass++;
`else
        run_access(1, 0, 0, 32'h500, 32'h0, 30, 32'h11223344);
        exp_rd = 32'h11223344;
        n_chk++;
        if (!ob_done || ob_stalls != 31 || !ob_stable)
            $display("FAIL nto_wait got stalls=%0d stable=%0b want 31/1",
                     ob_stalls, ob_stable);
        else n_pass++;
        n_chk++;
        if (bus.bus_err !== 1'b0 || read_dataM !== exp_rd)
            $display("FAIL nto_data got err=%b rd=%h want 0/%h",
                     bus.bus_err, read_dataM, exp_rd);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int          kind, nb;
            bit          rd, wr, st;
            logic [31:0] a, d, rdat, e_addr, e_wdata;
            logic [3:0]  e_strb;
            kind = $urandom_range(0, 2);
            rd = (kind != 1); wr = (kind != 0);
            st = $urandom_range(0, 1);
            a = $urandom; d = $urandom; rdat = $urandom;
            nb = $urandom_range(1, 4);
            e_addr = a & ~32'h3;
            e_strb = !wr ? 4'd0 : st ? 4'(1 << (a % 4)) : 4'hF;
            e_wdata = st ? (32'(d[7:0]) * 32'h01010101) : d;
            if (!wr) exp_rd = rdat;
            run_access(rd, wr, st, a, d, nb, rdat);
            n_chk++;
            if (!ob_done || ob_stalls != nb + 1 || !ob_stable || !ob_req_drop)
                $display("FAIL rnd%0d_seq got stalls=%0d stable=%0b drop=%0b want %0d",
                         i, ob_stalls, ob_stable, ob_req_drop, nb + 1);
            else n_pass++;
            n_chk++;
            if ({ob_addr, ob_we, ob_wstrb} !== {e_addr, wr, e_strb})
                $display("FAIL rnd%0d_bus got a=%h we=%b s=%b want %h/%b/%b",
                         i, ob_addr, ob_we, ob_wstrb, e_addr, wr, e_strb);
            else n_pass++;
            n_chk++;
            if ((wr && ob_wdata !== e_wdata) || read_dataM !== exp_rd)
                $display("FAIL rnd%0d_data got d=%h rd=%h want %h/%h",
                         i, ob_wdata, read_dataM, e_wdata, exp_rd);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1;
        mem_readM = 0; mem_writeM = 0; store_typeM = 0;
        addrM = 0; wdataM = 0;
        bus.bus_ack = 0; bus.bus_rdata = 0;
        exp_rd = 0;
        test_reset();
        test_word_load();
        test_byte_store();
        test_back_to_back();
        test_both_high();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
